hs_arbiter2: RTL
================

HS_ARBITER2 -- requirements
Module: hs_arbiter2

Interface
REQ-001 Parameter TIMEOUT, default 255, range 1..65535: max cycles hs_arbiter2 SHALL wait for each ack_out transition before flagging err.
REQ-002 Parameter SYNC_STAGES, default 2, range 2..3: synchronizer depth hs_arbiter2 SHALL apply to every asynchronous handshake input.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_in1  input  1  4-phase request from requester 1 (asynchronous to clk).
REQ-006 ack_in1  output  1  4-phase acknowledge to requester 1.
REQ-007 req_in2  input  1  4-phase request from requester 2 (asynchronous to clk).
REQ-008 ack_in2  output  1  4-phase acknowledge to requester 2.
REQ-009 req_out  output  1  request to the shared downstream fork/controller.
REQ-010 ack_out  input  1  acknowledge from the shared downstream (asynchronous to clk).
REQ-011 grant  output  2  one-hot owner: 01 = requester 1, 10 = requester 2, 00 = none.
REQ-012 err  output  1  sticky timeout flag.

Function
REQ-013 req_in1, req_in2 and ack_out SHALL each pass through a SYNC_STAGES flip-flop synchronizer; the FSM SHALL use only the synchronized copies.
REQ-014 All outputs SHALL be registered: no combinational path from any input to any output.
REQ-015 The FSM SHALL have states IDLE, REQ_HI, ACK_HI, REQ_LO, ACK_LO, FAULT.
REQ-016 In IDLE with exactly one synchronized request high, the FSM SHALL grant that requester, set grant, drive req_out=1 and go to REQ_HI.
REQ-017 In IDLE with both synchronized requests high in the same cycle, the FSM SHALL grant the requester not granted last (round-robin via register last).
REQ-018 In REQ_HI, on synchronized ack_out=1, the FSM SHALL drive the granted ack_inX=1 and go to ACK_HI.
REQ-019 In ACK_HI, on synchronized req_inX=0 of the granted requester, the FSM SHALL drive req_out=0 and go to REQ_LO.
REQ-020 In REQ_LO, on synchronized ack_out=0, the FSM SHALL drive ack_inX=0 and go to ACK_LO.
REQ-021 ACK_LO SHALL last exactly one cycle, then go to IDLE with grant=00 and last updated to the completed owner.
REQ-022 ack_inX of the non-granted requester SHALL remain 0 for the whole transaction; its pending request SHALL stay queued until IDLE.
REQ-023 Latency: req_out SHALL rise SYNC_STAGES+1 rising edges after the first edge sampling req_inX high from IDLE; each later handshake step SHALL take SYNC_STAGES+1 edges.
REQ-024 A 16-bit counter SHALL clear on entry to REQ_HI and REQ_LO and increment each cycle spent there.
REQ-025 When the counter reaches TIMEOUT, the FSM SHALL go to FAULT, set err=1, drive req_out=0, ack_in1=0, ack_in2=0 and grant=00.
REQ-026 FAULT SHALL be exited only by rst; err SHALL stay 1 until rst.
REQ-027 A request withdrawn before grant (glitch shorter than the sync latency) SHALL be ignored without a grant.

Reset
REQ-028 rst=1 SHALL immediately force: state=IDLE, req_out=0, ack_in1=0, ack_in2=0, grant=00, err=0, counter=0, all synchronizer flops=0, last=requester 2.
REQ-029 rst asserted mid-transaction SHALL abort it with the REQ-028 values; after release, still-high requests SHALL be arbitrated afresh.
REQ-030 After rst deassertion, the first tie SHALL be granted to requester 1.

Verification
REQ-031 Single requester: req_in1 up; downstream auto-acks after 2 cycles -> req_out rises at edge 3, full 4-phase completes, ack_in1 returns 0, grant returns 00.
REQ-032 Simultaneous requests x3 after reset -> grant sequence 01, 10, 01; ack_in2 never high during a requester-1 transaction.
REQ-033 Queued request: req_in2 rises during a requester-1 transaction -> req_out stays low until ACK_LO completes, then requester 2 is served.
REQ-034 Timeout: TIMEOUT=8, ack_out held 0 -> err=1 eight cycles after entering REQ_HI, all handshake outputs 0, err stays 1 until rst.
REQ-035 Reset mid-ACK_HI -> all outputs 0 asynchronously; req_in1 still high after release -> new grant 01 within SYNC_STAGES+1 edges.
REQ-036 One-cycle pulse on req_in2 in IDLE -> no grant and req_out stays 0.

Source files
------------

// File: rtl/hs_arbiter2.sv
// hs_arbiter2 -- two-requester arbiter for 4-phase (return-to-zero) handshakes.
//
// Two asynchronous requesters share a single downstream request/acknowledge
// pair. Every asynchronous input is passed through a SYNC_STAGES flip-flop
// synchronizer, and the FSM only looks at the synchronized copies. When both
// requesters ask in the same cycle, round-robin arbitration picks between them.
// If the downstream takes longer than TIMEOUT cycles for any ack_out edge, the
// FSM parks in FAULT until reset. FAULT drops every handshake output and
// raises err, which stays set.
//
// Parameters
//   TIMEOUT      cycles allowed per ack_out transition (1..65535)
//   SYNC_STAGES  synchronizer depth on req_in1/req_in2/ack_out (2..3)
// Ports
//   clk      single clock, rising edge
//   rst      asynchronous, active-high reset
//   req_in1  4-phase request from requester 1 (async)
//   ack_in1  4-phase acknowledge to requester 1 (registered)
//   req_in2  4-phase request from requester 2 (async)
//   ack_in2  4-phase acknowledge to requester 2 (registered)
//   req_out  request to the shared downstream (registered)
//   ack_out  acknowledge from the shared downstream (async)
//   grant    one-hot owner: 01 = requester 1, 10 = requester 2, 00 = none
//   err      sticky timeout flag
module hs_arbiter2 #(
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_in1,
  output logic       ack_in1,
  input  logic       req_in2,
  output logic       ack_in2,
  output logic       req_out,
  input  logic       ack_out,
  output logic [1:0] grant,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_HI = 3'd1,
    ACK_HI = 3'd2,
    REQ_LO = 3'd3,
    ACK_LO = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  // Bit 0 is the first (possibly metastable) flop, bit SYNC_STAGES-1 the output.
  logic [SYNC_STAGES-1:0] req1_sync;
  logic [SYNC_STAGES-1:0] req2_sync;
  logic [SYNC_STAGES-1:0] ack_sync;

  logic   req1_s, req2_s, ack_s;
  logic   req1_new, req2_new;
  state_t state;
  logic   last;          // 0 = requester 1 served last, 1 = requester 2
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req1_sync <= '0;
      req2_sync <= '0;
      ack_sync  <= '0;
    end else begin
      req1_sync <= {req1_sync[SYNC_STAGES-2:0], req_in1};
      req2_sync <= {req2_sync[SYNC_STAGES-2:0], req_in2};
      ack_sync  <= {ack_sync[SYNC_STAGES-2:0], ack_out};
    end
  end

  assign req1_s = req1_sync[SYNC_STAGES-1];
  assign req2_s = req2_sync[SYNC_STAGES-1];
  assign ack_s  = ack_sync[SYNC_STAGES-1];

  // A new request is only accepted when it is seen high in the last two
  // synchronizer stages. A request that was high for only one sample never
  // satisfies this, so a short glitch gets no grant. Grant latency is unchanged.
  assign req1_new = req1_sync[SYNC_STAGES-1] & req1_sync[SYNC_STAGES-2];
  assign req2_new = req2_sync[SYNC_STAGES-1] & req2_sync[SYNC_STAGES-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_out <= 1'b0;
      ack_in1 <= 1'b0;
      ack_in2 <= 1'b0;
      grant   <= 2'b00;
      err     <= 1'b0;
      cnt     <= 16'd0;
      last    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // On a tie, requester 1 wins only if requester 2 was served last.
          if (req1_new && (!req2_new || last)) begin
            grant   <= 2'b01;
            req_out <= 1'b1;
            cnt     <= 16'd0;
            state   <= REQ_HI;
          end else if (req2_new) begin
            grant   <= 2'b10;
            req_out <= 1'b1;
            cnt     <= 16'd0;
            state   <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            ack_in1 <= grant[0];
            ack_in2 <= grant[1];
            state   <= ACK_HI;
          end else if (cnt == CNT_LAST) begin
            state   <= FAULT;
            err     <= 1'b1;
            req_out <= 1'b0;
            ack_in1 <= 1'b0;
            ack_in2 <= 1'b0;
            grant   <= 2'b00;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ACK_HI: begin
          if ((grant[0] && !req1_s) || (grant[1] && !req2_s)) begin
            req_out <= 1'b0;
            cnt     <= 16'd0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            ack_in1 <= 1'b0;
            ack_in2 <= 1'b0;
            state   <= ACK_LO;
          end else if (cnt == CNT_LAST) begin
            state   <= FAULT;
            err     <= 1'b1;
            req_out <= 1'b0;
            ack_in1 <= 1'b0;
            ack_in2 <= 1'b0;
            grant   <= 2'b00;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ACK_LO: begin
          last  <= grant[1];
          grant <= 2'b00;
          state <= IDLE;
        end
        FAULT: begin
          // Only reset leaves FAULT; the outputs were already cleared on entry.
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
